display_hex_param_labkit: RTL

Parametrised driver for the labkit's serial dot-matrix hex displays. It shows NUM_CHARS hex digits from a flat nibble vector. Compared with the fixed 16-digit driver it adds three things: a configurable display-clock divider, runtime brightness with automatic control-register reload, and a coherent per-frame data snapshot with a frame-done strobe. It sits between user logic and the display pins at top level.

---
 rtl/display_hex_param_labkit.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/display_hex_param_labkit.sv
// Parametrised serial dot-matrix hex display driver with brightness reload and frame snapshot.
// Optional per-digit blanking is enabled by defining DISP_BLANK_MASK_EN.
module display_hex_param_labkit #(
    parameter int NUM_CHARS    = 16,
    parameter int CLK_DIV      = 27,
    parameter int RESET_CYCLES = 100
) (
    input  logic                   clock_27mhz,
    input  logic                   reset,
    input  logic [4*NUM_CHARS-1:0] data,
    input  logic [3:0]             brightness,
`ifdef DISP_BLANK_MASK_EN
    input  logic [NUM_CHARS-1:0]   blank_mask,
`endif
    output logic                   disp_blank,
    output logic                   disp_clock,
    output logic                   disp_rs,
    output logic                   disp_ce_b,
    output logic                   disp_reset_b,
    output logic                   disp_data_out,
    output logic                   frame_done
);

    localparam int DIV_W     = $clog2(CLK_DIV) + 1;
    localparam int HOLD_W    = $clog2(RESET_CYCLES + 1) + 1;
    localparam int INIT_DOTS = 40 * NUM_CHARS;
    localparam int CTRL_BITS = 2 * NUM_CHARS;
    localparam int CNT_W     = $clog2(INIT_DOTS) + 1;
    localparam int DIG_W     = $clog2(NUM_CHARS);

    typedef enum logic [2:0] {
        RST,
        ENDRST,
        INIT,
        LATCHI,
        CTRL,
        LATCH,
        CTRLSEL,
        SHIFT
    } state_t;

    function automatic logic [39:0] hex_glyph(input logic [3:0] n);
        logic [39:0] g;
        unique case (n)
            4'h0: g = 40'h3E_51_49_45_3E;
            4'h1: g = 40'h00_42_7F_40_00;
            4'h2: g = 40'h62_51_49_49_46;
            4'h3: g = 40'h22_41_49_49_36;
            4'h4: g = 40'h18_14_12_7F_10;
            4'h5: g = 40'h27_45_45_45_39;
            4'h6: g = 40'h3C_4A_49_49_30;
            4'h7: g = 40'h01_71_09_05_03;
            4'h8: g = 40'h36_49_49_49_36;
            4'h9: g = 40'h06_49_49_29_1E;
            4'hA: g = 40'h7E_09_09_09_7E;
            4'hB: g = 40'h7F_49_49_49_36;
            4'hC: g = 40'h3E_41_41_41_22;
            4'hD: g = 40'h7F_41_41_41_3E;
            4'hE: g = 40'h7F_49_49_49_41;
            4'hF: g = 40'h7F_09_09_09_01;
        endcase
        return g;
    endfunction

    logic [DIV_W-1:0]       div_cnt;
    logic                   clk_int;
    logic                   tick;
    logic [HOLD_W-1:0]      hold_cnt;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DIG_W-1:0]       dig_q, dig_d;
    logic [5:0]             dot_q, dot_d;
    logic [3:0]             bright_q, bright_d;
    logic [4*NUM_CHARS-1:0] frame_q, frame_d;
`ifdef DISP_BLANK_MASK_EN
    logic [NUM_CHARS-1:0]   mask_q, mask_d;
`endif

    logic                   rs_d;
    logic                   ce_b_d;
    logic                   reset_b_d;
    logic                   dout_d;
    logic                   done_d;

    logic [7:0]             ctrl_byte;
    logic [3:0]             cur_nib;
    logic [39:0]            cur_glyph;
    logic                   cur_dot;

    assign disp_blank = 1'b0;
    assign disp_clock = ~clk_int;

    // tick marks the cycle in which clk_int rises; all FSM work is gated on it
    assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1)) && !clk_int;
    assign ctrl_byte = {2'b01, 2'b11, bright_q};

    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            div_cnt  <= '0;
            clk_int  <= 1'b0;
            hold_cnt <= HOLD_W'(RESET_CYCLES);
        end else begin
            if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                div_cnt <= '0;
                clk_int <= ~clk_int;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        cur_nib   = frame_q[{dig_q, 2'b00} +: 4];
        cur_glyph = hex_glyph(cur_nib);
        cur_dot   = cur_glyph[dot_q];
`ifdef DISP_BLANK_MASK_EN
        if (mask_q[dig_q]) begin
            cur_dot = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dig_d     = dig_q;
        dot_d     = dot_q;
        bright_d  = bright_q;
        frame_d   = frame_q;
        rs_d      = disp_rs;
        ce_b_d    = disp_ce_b;
        reset_b_d = disp_reset_b;
        dout_d    = disp_data_out;
        done_d    = 1'b0;
`ifdef DISP_BLANK_MASK_EN
        mask_d    = mask_q;
`endif
        if (tick) begin
            unique case (state_q)
                RST: begin
                    if (hold_cnt == '0) begin
                        reset_b_d = 1'b0;
                        ce_b_d    = 1'b1;
                        rs_d      = 1'b0;
                        dout_d    = 1'b0;
                        state_d   = ENDRST;
                    end
                end
                ENDRST: begin
                    reset_b_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = INIT;
                end
                INIT: begin
                    ce_b_d = 1'b0;
                    dout_d = 1'b0;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(INIT_DOTS - 1)) begin
                        state_d = LATCHI;
                    end
                end
                LATCHI: begin
                    ce_b_d   = 1'b1;
                    rs_d     = 1'b1;
                    bright_d = brightness;
                    cnt_d    = '0;
                    state_d  = CTRL;
                end
                CTRL: begin
                    ce_b_d = 1'b0;
                    dout_d = ctrl_byte[3'd7 - cnt_q[2:0]];
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(CTRL_BITS - 1)) begin
                        state_d = LATCH;
                    end
                end
                LATCH: begin
                    ce_b_d = 1'b1;
                    rs_d   = 1'b0;
                    dout_d = 1'b0;
                    // a pending brightness change is flushed before the next frame
                    if (bright_q != brightness) begin
                        state_d = CTRLSEL;
                    end else begin
                        frame_d = data;
`ifdef DISP_BLANK_MASK_EN
                        mask_d  = blank_mask;
`endif
                        dig_d   = DIG_W'(NUM_CHARS - 1);
                        dot_d   = 6'd39;
                        state_d = SHIFT;
                    end
                end
                CTRLSEL: begin
                    ce_b_d   = 1'b1;
                    rs_d     = 1'b1;
                    bright_d = brightness;
                    cnt_d    = '0;
                    state_d  = CTRL;
                end
                SHIFT: begin
                    ce_b_d = 1'b0;
                    dout_d = cur_dot;
                    if (dot_q == 6'd0) begin
                        dot_d = 6'd39;
                        if (dig_q == '0) begin
                            done_d  = 1'b1;
                            state_d = LATCH;
                        end else begin
                            dig_d = dig_q - 1'b1;
                        end
                    end else begin
                        dot_d = dot_q - 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            state_q       <= RST;
            cnt_q         <= '0;
            dig_q         <= '0;
            dot_q         <= '0;
            bright_q      <= '0;
            frame_q       <= '0;
`ifdef DISP_BLANK_MASK_EN
            mask_q        <= '0;
`endif
            disp_rs       <= 1'b0;
            disp_ce_b     <= 1'b1;
            disp_reset_b  <= 1'b0;
            disp_data_out <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dig_q         <= dig_d;
            dot_q         <= dot_d;
            bright_q      <= bright_d;
            frame_q       <= frame_d;
`ifdef DISP_BLANK_MASK_EN
            mask_q        <= mask_d;
`endif
            disp_rs       <= rs_d;
            disp_ce_b     <= ce_b_d;
            disp_reset_b  <= reset_b_d;
            disp_data_out <= dout_d;
            frame_done    <= done_d;
        end
    end

endmodule
